// File: rtl/mvm_pkg.sv
// Shared types and constants for the matrix-vector multiply controller.
package mvm_pkg;

  // Controller phases
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // A-row memory read latency in cycles
  localparam int unsigned RD_LAT  = 1;

  // X vector is streamed as three 24-bit beats of three 8-bit elements
  localparam int unsigned X_W     = 24;
  localparam int unsigned X_BEATS = 3;

endpackage

// File: rtl/mvm_align_pipe.sv
// Fixed-depth delay line used to align enables and addresses with the datapath.
module mvm_align_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_dly
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift register, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= sig;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign sig_dly = stage[DEPTH-1];

endmodule

// File: rtl/mvm_ctrl.sv
// Sequencer for a matrix-vector multiply: loads X, streams A-row reads, counts writebacks.
module mvm_ctrl
  import mvm_pkg::*;
#(
  parameter int unsigned ROWS   = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   n_rows,
  input  logic              x_valid,
  input  logic [X_W-1:0]    x_data,
  output logic              x_ready,
  output logic [X_W-1:0]    x_reg1,
  output logic [X_W-1:0]    x_reg2,
  output logic [X_W-1:0]    x_reg3,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_addr,
  output logic              alu_en,
  input  logic              alu_web,
  output logic [ADDR_W-1:0] res_addr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] ROWS_MAX = CNT_W'(ROWS);
  localparam logic [1:0]       LAST_BEAT = 2'(X_BEATS - 1);

  state_t             state;
  logic [CNT_W-1:0]   n_lat;
  logic [CNT_W-1:0]   rd_cnt;
  logic [CNT_W-1:0]   wb_cnt;
  logic [1:0]         x_cnt;
  logic [CNT_W:0]     wb_sum_c;

  // Writebacks including the one arriving this cycle, so DONE lines up with the last alu_web
  assign wb_sum_c = {1'b0, wb_cnt} + (CNT_W+1)'(alu_web);

  assign a_addr = rd_cnt[ADDR_W-1:0];

  // Controller FSM with registered outputs and job counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      n_lat   <= '0;
      rd_cnt  <= '0;
      wb_cnt  <= '0;
      x_cnt   <= '0;
      x_ready <= 1'b0;
      x_reg1  <= '0;
      x_reg2  <= '0;
      x_reg3  <= '0;
      a_rd_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;

      // Writebacks only count inside a job; saturate rather than wrap
      if (busy && alu_web && (wb_cnt != '1)) wb_cnt <= wb_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          if (start) begin
            n_lat   <= (n_rows > ROWS_MAX) ? ROWS_MAX : n_rows;
            x_cnt   <= '0;
            wb_cnt  <= '0;
            rd_cnt  <= '0;
            x_ready <= 1'b1;
            busy    <= 1'b1;
            state   <= LOAD_X;
          end
        end

        LOAD_X: begin
          if (x_valid) begin
            case (x_cnt)
              2'd0:    x_reg1 <= x_data;
              2'd1:    x_reg2 <= x_data;
              2'd2:    x_reg3 <= x_data;
              default: ;
            endcase
            if (x_cnt == LAST_BEAT) begin
              x_ready <= 1'b0;
              if (n_lat == '0) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                a_rd_en <= 1'b1;
                rd_cnt  <= '0;
                state   <= RUN;
              end
            end else begin
              x_cnt <= x_cnt + 2'd1;
            end
          end
        end

        RUN: begin
          if (rd_cnt == n_lat - CNT_W'(1)) begin
            a_rd_en <= 1'b0;
            state   <= DRAIN;
          end else begin
            rd_cnt <= rd_cnt + CNT_W'(1);
          end
        end

        DRAIN: begin
          if (wb_sum_c == {1'b0, n_lat}) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          a_rd_en <= 1'b0;
          x_ready <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Data from the A memory arrives RD_LAT cycles after the read strobe
  mvm_align_pipe #(
    .DEPTH (RD_LAT),
    .WIDTH (1)
  ) u_en_pipe (
    .clk     (clk),
    .rst     (rst),
    .sig     (a_rd_en),
    .sig_dly (alu_en)
  );

  // Result address trails the read address by memory latency plus one MAC stage
  mvm_align_pipe #(
    .DEPTH (RD_LAT + 1),
    .WIDTH (ADDR_W)
  ) u_addr_pipe (
    .clk     (clk),
    .rst     (rst),
    .sig     (a_addr),
    .sig_dly (res_addr)
  );

endmodule

// File: tb/tb_mvm_ctrl.sv
// Scoreboard bench for mvm_ctrl with A-memory and MAC models.
module tb_mvm_ctrl;
  import mvm_pkg::*;

  localparam int unsigned ROWS   = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst, start, x_valid, x_ready, a_rd_en, alu_en, alu_web, busy, done;
  logic [ADDR_W:0]   n_rows;
  logic [23:0]       x_data, x_reg1, x_reg2, x_reg3;
  logic [ADDR_W-1:0] a_addr, res_addr;

  mvm_ctrl #(.ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_rows(n_rows),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .x_reg1(x_reg1), .x_reg2(x_reg2), .x_reg3(x_reg3),
    .a_rd_en(a_rd_en), .a_addr(a_addr), .alu_en(alu_en), .alu_web(alu_web),
    .res_addr(res_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // A memory (1-cycle read) and MAC datapath models
  logic [71:0] mem [ROWS];
  logic [71:0] a_data;
  logic        mac_web, noise;
  int          mac_sum;

  function automatic int dot(input logic [71:0] a, input logic [71:0] x);
    int s = 0;
    for (int k = 0; k < 9; k++) s += int'(a[8*k +: 8]) * int'(x[8*k +: 8]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      a_data  <= '0;
      mac_web <= 1'b0;
      mac_sum <= 0;
    end else begin
      if (a_rd_en) a_data <= mem[a_addr];
      mac_web <= alu_en;
      if (alu_en) mac_sum <= dot(a_data, {x_reg3, x_reg2, x_reg1});
    end
  end

  assign alu_web = mac_web | noise;

  // Scoreboard
  typedef struct {int addr; int cyc; int sum;} ev_t;
  ev_t  exp_rd[$];
  ev_t  exp_res[$];
  int   exp_done[$];
  ev_t  mon_e;
  int   mon_d;
  logic exp_alu;
  bit   mon_on = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_rd_en"}, a_rd_en, 0);
    chk({tag, "_a_addr"}, a_addr, 0);
    chk({tag, "_alu_en"}, alu_en, 0);
    chk({tag, "_res_addr"}, res_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_x_ready"}, x_ready, 0);
    chk({tag, "_x_reg1"}, x_reg1, 0);
    chk({tag, "_x_reg2"}, x_reg2, 0);
    chk({tag, "_x_reg3"}, x_reg3, 0);
  endtask

  always @(posedge clk) exp_alu <= rst ? 1'b0 : a_rd_en;

  // Monitor: compare every presented read, writeback and done against the queues
  always @(negedge clk) begin
    if (mon_on) begin
      chk("alu_en_align", alu_en, exp_alu);
      if (a_rd_en === 1'b1) begin
        if (exp_rd.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          mon_e = exp_rd.pop_front();
          chk("rd_addr", a_addr, mon_e.addr);
          chk("rd_cycle", cyc, mon_e.cyc);
        end
      end
      if (mac_web === 1'b1) begin
        if (exp_res.size() == 0) chk("unexpected_writeback", 1, 0);
        else begin
          mon_e = exp_res.pop_front();
          chk("res_addr", res_addr, mon_e.addr);
          chk("res_cycle", cyc, mon_e.cyc);
          chk("res_sum", mac_sum, mon_e.sum);
        end
      end
      if (done === 1'b1) begin
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mon_d = exp_done.pop_front();
          chk("done_cycle", cyc, mon_d);
        end
      end
    end
  end

  // One job: reference expectations are pushed before stimulus is applied
  task automatic run_job(input int n, input int stall, input bit inj, input int abort_at, input bit fixed_x);
    int          ne;
    int          acc;
    int          base;
    logic [23:0] bx [3];
    logic [71:0] xv;
    bit          got;
    ne = (n > int'(ROWS)) ? int'(ROWS) : n;
    if (fixed_x) begin
      bx[0] = 24'h030201; bx[1] = 24'h060504; bx[2] = 24'h090807;
    end else begin
      for (int b = 0; b < 3; b++) bx[b] = 24'($urandom);
    end
    for (int r = 0; r < int'(ROWS); r++) mem[r] = {8'($urandom), 32'($urandom), 32'($urandom)};
    xv   = {bx[2], bx[1], bx[0]};
    acc  = cyc;
    base = acc + 4 + stall;
    for (int r = 0; r < ne; r++) begin
      exp_rd.push_back('{r, base + r, 0});
      exp_res.push_back('{r, base + 2 + r, dot(mem[r], xv)});
    end
    if (abort_at < 0) exp_done.push_back(ne > 0 ? base + ne + 2 : base);

    start = 1'b1; n_rows = (ADDR_W+1)'(n);
    @(posedge clk); #1 start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      if (b == 2) begin
        repeat (stall) begin
          x_valid = 1'b0;
          @(negedge clk); chk("x_ready_stall", x_ready, 1);
          @(posedge clk); #1;
        end
      end
      x_valid = 1'b1; x_data = bx[b];
      @(negedge clk);
      chk("x_ready_beat", x_ready, 1);
      chk("busy_load", busy, 1);
      @(posedge clk); #1;
      x_valid = 1'b0; x_data = 24'($urandom);
    end
    chk("x_reg1", x_reg1, bx[0]);
    chk("x_reg2", x_reg2, bx[1]);
    chk("x_reg3", x_reg3, bx[2]);

    if (abort_at >= 0) begin
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (a_rd_en === 1'b1 && int'(a_addr) == abort_at) got = 1'b1;
      end
      chk("abort_point", got, 1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      exp_rd.delete(); exp_res.delete(); exp_done.delete();
      @(negedge clk);
      chk_reset_outputs("abort");
      return;
    end

    if (inj && ne > 0) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end

    got = 1'b0;
    for (int i = 0; i < 120 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    chk("done_seen", got, 1);
    if (inj) begin
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk); chk("start_in_done_ignored", busy, 0);
    end
    @(posedge clk); #1;
  endtask

  // Spurious writeback flag while idle
  task automatic noise_pulse();
    noise = 1'b1;
    @(posedge clk); #1 noise = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n_rows = '0; x_valid = 1'b0; x_data = '0; noise = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0; mon_on = 1'b1;

    run_job(4, 0, 1'b0, -1, 1'b1);
    run_job(4, 5, 1'b0, -1, 1'b0);
    run_job(0, 0, 1'b0, -1, 1'b0);
    run_job(20, 0, 1'b0, -1, 1'b0);
    noise_pulse();
    run_job(1, 0, 1'b1, -1, 1'b0);
    run_job(16, 2, 1'b1, -1, 1'b0);
    run_job(8, 0, 1'b0, 2, 1'b0);
    run_job(5, 0, 1'b0, -1, 1'b0);
    for (int j = 0; j < 10; j++) begin
      if ($urandom_range(0, 1) == 1) noise_pulse();
      run_job(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), -1, 1'b0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("exp_rd_empty", exp_rd.size(), 0);
    chk("exp_res_empty", exp_res.size(), 0);
    chk("exp_done_empty", exp_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
